// File: rtl/button_interrupt_unit_pkg.sv
// Shared definitions for the push-button interrupt front end: FSM state
// encodings, the default debounce length and the button index constants
// that the I/O manager address map also uses.
package button_interrupt_unit_pkg;

    localparam int N_BTN_DEFAULT      = 4;
    localparam int DEB_CYCLES_DEFAULT = 50000;   // 1 ms at 50 MHz
    localparam int CNT_W_DEFAULT      = 16;

    // Button indices shared with the I/O manager address map.
    localparam int BTN_0 = 0;
    localparam int BTN_1 = 1;
    localparam int BTN_2 = 2;
    localparam int BTN_3 = 3;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/button_interrupt_unit_if.sv
// Signal bundle between the board/CPU side and the button interrupt unit.
// Handshake: intr_req is held high with a stable intr_vector until the CPU
// raises intr_ack (a level); the request is then dropped and a new one is
// only presented after intr_ack has returned low.
interface button_interrupt_unit_if
    import button_interrupt_unit_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT,
    parameter int VEC_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) ();

    logic [N_BTN-1:0] buttons_raw;
    logic [N_BTN-1:0] intr_enable;
    logic             intr_ack;
    logic [N_BTN-1:0] buttons;
    logic             intr_req;
    logic [VEC_W-1:0] intr_vector;
    logic [N_BTN-1:0] pending;
    state_t           dbg_state;

    // Board pins plus CPU side.
    modport master (
        output buttons_raw, intr_enable, intr_ack,
        input  buttons, intr_req, intr_vector, pending, dbg_state
    );

    // The interrupt unit itself.
    modport slave (
        input  buttons_raw, intr_enable, intr_ack,
        output buttons, intr_req, intr_vector, pending, dbg_state
    );

endinterface

// File: rtl/button_interrupt_unit_debouncer.sv
// One-bit synchroniser and debouncer. The stable output only follows the
// synchronised level once it has disagreed with it for DEB_CYCLES
// consecutive cycles; any bounce back restarts the count.
module button_interrupt_unit_debouncer #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             raw_pressed;

    assign raw_pressed = (ACTIVE_LOW != 0) ? ~raw : raw;

    // Two-flop synchroniser, then count how long the synced level disagrees.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync0 <= raw_pressed;
            sync1 <= sync0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_interrupt_unit.sv
// Push-button front end: debounced levels for the I/O manager, press edges
// latched as pending interrupts, and a fixed-priority req/ack presenter
// (index 0 highest) that hands one interrupt at a time to the CPU.
module button_interrupt_unit
    import button_interrupt_unit_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    button_interrupt_unit_if.slave bus
);

    localparam int VEC_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0] buttons_q;
    logic [N_BTN-1:0] buttons_prev;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending_q;
    logic [N_BTN-1:0] pending_d;
    logic [VEC_W-1:0] low_idx;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;
    logic             req;
    logic             service;
    state_t           state_q;
    state_t           state_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        button_interrupt_unit_debouncer #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.buttons_raw[i]),
            .stable (buttons_q[i])
        );
    end

    // Previous debounced level, for rising-edge (press) detection.
    always_ff @(posedge clk) begin
        if (reset) buttons_prev <= '0;
        else       buttons_prev <= buttons_q;
    end

    assign press   = buttons_q & ~buttons_prev;
    assign service = (state_q == ST_REQ) && bus.intr_ack;

    // Pending update: ack clear, then disable clear, then a new press wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (service && (vec_q == VEC_W'(i))) pending_d[i] = 1'b0;
            if (!bus.intr_enable[i])             pending_d[i] = 1'b0;
            if (press[i] && bus.intr_enable[i])  pending_d[i] = 1'b1;
        end
    end

    // Lowest set pending index; scanning downward lets index 0 win.
    always_comb begin
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = VEC_W'(i);
        end
    end

    // Request FSM next state and outputs.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    vec_d   = low_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (bus.intr_ack)           state_d = ST_WAIT_ACK_LOW;
                else if (!pending_q[vec_q]) state_d = ST_IDLE;
            end
            ST_WAIT_ACK_LOW: begin
                if (!bus.intr_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, vector and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            pending_q <= pending_d;
        end
    end

    assign bus.buttons     = buttons_q;
    assign bus.pending     = pending_q;
    assign bus.intr_req    = req;
    assign bus.intr_vector = vec_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_button_interrupt_unit.sv
// Directed bench for button_interrupt_unit with DEB_CYCLES=4, ACTIVE_LOW=0.
module tb_button_interrupt_unit;
    import button_interrupt_unit_pkg::*;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    button_interrupt_unit_if #(.N_BTN(4)) bus ();

    button_interrupt_unit #(
        .N_BTN      (4),
        .DEB_CYCLES (4),
        .CNT_W      (16),
        .ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] en;
        logic       ack;
        logic [3:0] exp_btn;
        logic [3:0] exp_pend;
        logic       exp_req;
        logic [1:0] exp_vec;
    } vec_t;

    vec_t tbl[10];

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic release_all(input string name);
        bus.buttons_raw = 4'b0000;
        bus.intr_ack    = 1'b0;
        steps(10);
        check({name, "_btn"},  32'(bus.buttons), 32'h0);
        check({name, "_pend"}, 32'(bus.pending), 32'h0);
        check({name, "_req"},  32'(bus.intr_req), 32'h0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        // Single press of btn2, cycle by cycle from the raw edge.
        tbl[0] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[2] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[3] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[4] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[5] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0};
        tbl[6] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0};
        tbl[7] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2};
        tbl[8] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0};
        tbl[9] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0};

        reset           = 1'b1;
        bus.buttons_raw = 4'b0000;
        bus.intr_enable = 4'b1111;
        bus.intr_ack    = 1'b0;
        steps(3);
        reset = 1'b0;
        check("rst_btn",   32'(bus.buttons),     32'h0);
        check("rst_pend",  32'(bus.pending),     32'h0);
        check("rst_req",   32'(bus.intr_req),    32'h0);
        check("rst_vec",   32'(bus.intr_vector), 32'h0);
        check("rst_state", 32'(bus.dbg_state),   32'(ST_IDLE));

        // 1: bouncing raw[0] never reaches the debounced level
        for (int k = 0; k < 16; k++) begin
            bus.buttons_raw = (k < 8 && ((k / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
            step();
            check("bounce_btn", 32'(bus.buttons),  32'h0);
            check("bounce_req", 32'(bus.intr_req), 32'h0);
        end
        check("bounce_pend", 32'(bus.pending), 32'h0);

        // 2: table-driven single press and service
        for (int i = 0; i < 10; i++) begin
            bus.buttons_raw = tbl[i].raw;
            bus.intr_enable = tbl[i].en;
            bus.intr_ack    = tbl[i].ack;
            step();
            check($sformatf("tbl%0d_btn", i),  32'(bus.buttons),  32'(tbl[i].exp_btn));
            check($sformatf("tbl%0d_pend", i), 32'(bus.pending),  32'(tbl[i].exp_pend));
            check($sformatf("tbl%0d_req", i),  32'(bus.intr_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req)
                check($sformatf("tbl%0d_vec", i), 32'(bus.intr_vector), 32'(tbl[i].exp_vec));
        end
        release_all("rel2");

        // 3: btn1 and btn3 together, btn1 served first
        bus.buttons_raw = 4'b1010;
        steps(7);
        check("two_pend", 32'(bus.pending), 32'hA);
        step();
        check("two_req1", 32'(bus.intr_req),    32'h1);
        check("two_vec1", 32'(bus.intr_vector), 32'h1);
        bus.intr_ack = 1'b1;
        step();
        check("two_ack_pend", 32'(bus.pending),  32'h8);
        check("two_ack_req",  32'(bus.intr_req), 32'h0);
        step();
        check("two_hold_ack_req", 32'(bus.intr_req), 32'h0);
        bus.intr_ack = 1'b0;
        step();
        check("two_idle_req", 32'(bus.intr_req), 32'h0);
        step();
        check("two_req2",  32'(bus.intr_req),    32'h1);
        check("two_vec2",  32'(bus.intr_vector), 32'h3);
        check("two_pend2", 32'(bus.pending),     32'h8);
        bus.intr_ack = 1'b1;
        step();
        check("two_done_pend", 32'(bus.pending), 32'h0);
        bus.intr_ack = 1'b0;
        step();
        release_all("rel3");

        // 4: re-press of btn2 coincides with the ack of vector 2
        bus.buttons_raw = 4'b0100;
        steps(8);
        check("repress_req1", 32'(bus.intr_req),    32'h1);
        check("repress_vec1", 32'(bus.intr_vector), 32'h2);
        bus.buttons_raw = 4'b0000;
        steps(6);
        check("repress_rel_btn", 32'(bus.buttons), 32'h0);
        bus.buttons_raw = 4'b0100;
        steps(6);
        check("repress_btn", 32'(bus.buttons), 32'h4);
        bus.intr_ack = 1'b1;
        step();
        check("repress_pend", 32'(bus.pending),  32'h4);
        check("repress_wait", 32'(bus.intr_req), 32'h0);
        bus.intr_ack = 1'b0;
        steps(2);
        check("repress_req2", 32'(bus.intr_req),    32'h1);
        check("repress_vec2", 32'(bus.intr_vector), 32'h2);
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
        step();
        release_all("rel4");

        // 5: disabled button and disable during REQ
        bus.intr_enable = 4'b1110;
        bus.buttons_raw = 4'b0001;
        steps(8);
        check("dis_btn",  32'(bus.buttons),  32'h1);
        check("dis_pend", 32'(bus.pending),  32'h0);
        check("dis_req",  32'(bus.intr_req), 32'h0);
        release_all("rel5a");
        bus.intr_enable = 4'b1111;
        bus.buttons_raw = 4'b0010;
        steps(8);
        check("drop_req1", 32'(bus.intr_req),    32'h1);
        check("drop_vec1", 32'(bus.intr_vector), 32'h1);
        bus.intr_enable = 4'b1101;
        step();
        check("drop_pend", 32'(bus.pending), 32'h0);
        step();
        check("drop_req",   32'(bus.intr_req),  32'h0);
        check("drop_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        bus.intr_enable = 4'b1111;
        release_all("rel5b");

        // 6: reset during REQ with two pending
        bus.buttons_raw = 4'b1010;
        steps(8);
        check("mid_pend", 32'(bus.pending),  32'hA);
        check("mid_req",  32'(bus.intr_req), 32'h1);
        reset           = 1'b1;
        bus.buttons_raw = 4'b0000;
        step();
        reset = 1'b0;
        check("mrst_btn",   32'(bus.buttons),     32'h0);
        check("mrst_pend",  32'(bus.pending),     32'h0);
        check("mrst_req",   32'(bus.intr_req),    32'h0);
        check("mrst_vec",   32'(bus.intr_vector), 32'h0);
        check("mrst_state", 32'(bus.dbg_state),   32'(ST_IDLE));
        release_all("rel6");

        // Final report
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
